// File: rtl/cond_eval_unit.sv
// cond_eval_unit: NZCV flag sets with a condition-code evaluator behind a valid/ready result register.
module cond_eval_unit #(
  parameter int         FLAG_SETS   = 2,
  parameter int         SEL_W       = (FLAG_SETS > 1) ? $clog2(FLAG_SETS) : 1,
  parameter bit         BYPASS      = 1'b1,
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter int         CNT_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flags_we_i,
  input  logic [SEL_W-1:0] flags_set_i,
  input  logic [3:0]       alu_flags_i,
  input  logic             eval_valid_i,
  output logic             eval_ready_o,
  input  logic [3:0]       cond_i,
  input  logic [SEL_W-1:0] eval_set_i,
  output logic             signal_valid_o,
  input  logic             signal_ready_i,
  output logic             signal_o,
  output logic [3:0]       flags_o,
  output logic [CNT_W-1:0] taken_cnt_o
);
  logic [3:0]       flags_q [FLAG_SETS];
  logic             signal_valid_q, signal_valid_d;
  logic             signal_q, signal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] wr_idx, ev_idx;
  logic [3:0]       ev_flags;
  logic [15:0]      tbl;
  logic             n, z, c, v, res, accept;
  assign wr_idx = (32'(flags_set_i) < FLAG_SETS) ? flags_set_i : '0;
  assign ev_idx = (32'(eval_set_i) < FLAG_SETS) ? eval_set_i : '0;
  assign flags_o = flags_q[ev_idx];
  assign ev_flags = (BYPASS && flags_we_i && wr_idx == ev_idx) ? alu_flags_i : flags_q[ev_idx];
  assign {n, z, c, v} = ev_flags;
  // Truth table indexed by condition code, EQ at bit 0 through NV at bit 15.
  assign tbl = {1'b0, 1'b1, z | (n ^ v), ~z & ~(n ^ v), n ^ v, ~(n ^ v), ~c | z, c & ~z,
                ~v, v, ~n, n, ~c, c, ~z, z};
  assign res = tbl[cond_i];
  assign eval_ready_o = ~signal_valid_q | signal_ready_i;
  assign accept = eval_valid_i & eval_ready_o;
  always_comb begin
    signal_valid_d = accept | (signal_valid_q & ~signal_ready_i);
    signal_d = accept ? res : signal_q;
    cnt_d = (accept && res && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FLAG_SETS; i++) flags_q[i] <= RESET_FLAGS;
      signal_valid_q <= 1'b0;
      signal_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (flags_we_i) flags_q[wr_idx] <= alu_flags_i;
      signal_valid_q <= signal_valid_d;
      signal_q <= signal_d;
      cnt_q <= cnt_d;
    end
  end
  assign signal_valid_o = signal_valid_q;
  assign signal_o = signal_q;
  assign taken_cnt_o = cnt_q;
endmodule
